// File: rtl/rvm_ctrl_seq.sv
// rtl/rvm_ctrl_seq.sv - multi-cycle control sequencer with memory handshakes, traps and retire counter
module rvm_ctrl_seq #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = 8,
    parameter int MC_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             imem_err,
    output logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    input  logic             dec_illegal,
    input  logic             dec_is_mem,
    input  logic [MC_W-1:0]  dec_mc_len,
    input  logic             dec_wb,
    input  logic             irq,
    output logic             ir_load,
    output logic             rf_wen,
    output logic             pc_update,
    output logic             trap_take,
    output logic [3:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_TRAP   = 4'd6
    } state_t;

    localparam logic [TMR_W-1:0] TMO    = TMR_W'(MEM_TIMEOUT);
    localparam bit               TMO_EN = (MEM_TIMEOUT != 0);

    localparam logic [3:0] CAUSE_IFAULT  = 4'h1;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'h2;
    localparam logic [3:0] CAUSE_DFAULT  = 4'h5;
    localparam logic [3:0] CAUSE_IRQ     = 4'hB;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [MC_W-1:0]   mc_cnt;
    logic [MC_W-1:0]   mc_nxt;
    logic [3:0]        cause_nxt;
    logic              timed_out;

    assign timed_out = TMO_EN && (tmr == TMO);
    assign state_o   = state;

    always_comb begin
        state_nxt = state;
        mc_nxt    = mc_cnt;
        cause_nxt = trap_cause;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ir_load   = 1'b0;
        rf_wen    = 1'b0;
        pc_update = 1'b0;
        trap_take = 1'b0;
        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack & ~imem_err;
                if (imem_err) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_IFAULT;
                end else if (imem_ack) begin
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_IFAULT;
                end
            end
            S_DECODE: begin
                if (irq) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_IRQ;
                end else if (dec_illegal) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (dec_mc_len != '0) begin
                    state_nxt = S_EXEC;
                    mc_nxt    = dec_mc_len - MC_W'(1);
                end else if (dec_is_mem) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_EXEC: begin
                if (mc_cnt == '0) begin
                    state_nxt = dec_is_mem ? S_MEM : S_WB;
                end else begin
                    mc_nxt = mc_cnt - MC_W'(1);
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_err) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_DFAULT;
                end else if (dmem_ack) begin
                    state_nxt = S_WB;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_DFAULT;
                end
            end
            S_WB: begin
                pc_update = 1'b1;
                rf_wen    = dec_wb;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                pc_update = 1'b1;
                trap_take = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_RESET;
            tmr        <= '0;
            mc_cnt     <= '0;
            trap_cause <= '0;
            instret    <= '0;
        end else begin
            state      <= state_nxt;
            mc_cnt     <= mc_nxt;
            trap_cause <= cause_nxt;
            if (state == S_WB) begin
                instret <= instret + CNT_W'(1);
            end
            // wait timer restarts on each new handshake and saturates while stalled
            if ((state_nxt == S_FETCH || state_nxt == S_MEM) && state_nxt != state) begin
                tmr <= '0;
            end else if ((state == S_FETCH || state == S_MEM) && tmr != '1) begin
                tmr <= tmr + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rvm_ctrl_seq.sv
// tb/tb_rvm_ctrl_seq.sv - table-driven scoreboard bench for rvm_ctrl_seq
module tb_rvm_ctrl_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       imem_req, imem_ack, imem_err;
    logic       dmem_req, dmem_ack, dmem_err;
    logic       dec_illegal, dec_is_mem, dec_wb, irq;
    logic [4:0] dec_mc_len;
    logic       ir_load, rf_wen, pc_update, trap_take;
    logic [3:0] trap_cause;
    logic [3:0] instret;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    rvm_ctrl_seq #(.MEM_TIMEOUT(4), .TMR_W(8), .MC_W(5), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_err(imem_err),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .dec_illegal(dec_illegal), .dec_is_mem(dec_is_mem), .dec_mc_len(dec_mc_len),
        .dec_wb(dec_wb), .irq(irq),
        .ir_load(ir_load), .rf_wen(rf_wen), .pc_update(pc_update), .trap_take(trap_take),
        .trap_cause(trap_cause), .instret(instret), .state_o(state_o)
    );

    typedef struct {
        int       iwait;
        bit       ierr;
        bit       inever;
        bit       illegal;
        bit       is_mem;
        int       mc_len;
        bit       wb;
        bit       irq;
        int       dwait;
        bit       derr;
        bit       dnever;
        int       e_cycles;
        int       e_ireq;
        int       e_dreq;
        int       e_exec;
        int       e_rfw;
        bit       e_trap;
        logic [3:0] e_cause;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];
    int   nvec = 0;
    int   nfail = 0;
    logic [3:0] m_instret = 4'd0;
    logic [3:0] m_cause = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        imem_ack = 0; imem_err = 0; dmem_ack = 0; dmem_err = 0;
        dec_illegal = 0; dec_is_mem = 0; dec_mc_len = 0; dec_wb = 0; irq = 0;
    endtask

    // Entered and left at a falling edge with the DUT in FETCH.
    task automatic do_instr(input vec_t v, input string tag);
        vec_t e;
        int cyc = 0, ireq = 0, dreq = 0, exec_n = 0, rfw = 0, trp = 0, pcu = 0, irl = 0;
        int fcnt = 0, mcnt = 0;
        bit done = 0;
        sb_q.push_back(v);
        dec_illegal = v.illegal; dec_is_mem = v.is_mem; dec_mc_len = 5'(v.mc_len);
        dec_wb = v.wb; irq = v.irq;
        while (!done && cyc < 200) begin
            imem_ack = (state_o == 4'd1) && !v.inever && (fcnt == v.iwait);
            imem_err = imem_ack && v.ierr;
            dmem_ack = (state_o == 4'd4) && !v.dnever && (mcnt == v.dwait);
            dmem_err = dmem_ack && v.derr;
            #1;
            ireq += int'(imem_req); dreq += int'(dmem_req); rfw += int'(rf_wen);
            trp += int'(trap_take); pcu += int'(pc_update); irl += int'(ir_load);
            if (state_o == 4'd3) exec_n++;
            if (state_o == 4'd1) fcnt++;
            if (state_o == 4'd4) mcnt++;
            if (state_o == 4'd5 || state_o == 4'd6) done = 1;
            cyc++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        if (!done) check({tag, " watchdog"}, cyc, -1);
        if (!e.e_trap) m_instret = m_instret + 4'd1;
        else m_cause = e.e_cause;
        check({tag, " cycles"}, cyc, e.e_cycles);
        check({tag, " imem_req"}, ireq, e.e_ireq);
        check({tag, " dmem_req"}, dreq, e.e_dreq);
        check({tag, " exec"}, exec_n, e.e_exec);
        check({tag, " rf_wen"}, rfw, e.e_rfw);
        check({tag, " trap_take"}, trp, int'(e.e_trap));
        check({tag, " pc_update"}, pcu, 1);
        check({tag, " ir_load"}, irl, (e.inever || e.ierr) ? 0 : 1);
        check({tag, " trap_cause"}, int'(trap_cause), int'(m_cause));
        check({tag, " instret"}, int'(instret), int'(m_instret));
        check({tag, " back_in_fetch"}, int'(state_o), 1);
    endtask

    initial begin
        //        iw ie in il im mc wb irq dw de dn | cyc ireq dreq exec rfw trap cause
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  3, 1, 0, 0, 1, 0, 4'h0};
        vecs[1]  = '{0, 0, 0, 0, 1, 0, 1, 0,  3, 0, 0,  7, 1, 4, 0, 1, 0, 4'h0};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 1, 0,  0, 0, 0,  6, 5, 0, 0, 0, 1, 4'h1};
        vecs[3]  = '{0, 0, 0, 0, 0, 3, 0, 0,  0, 0, 0,  6, 1, 0, 3, 0, 0, 4'h0};
        vecs[4]  = '{2, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  5, 3, 0, 0, 1, 0, 4'h0};
        vecs[5]  = '{0, 0, 0, 1, 0, 0, 1, 1,  0, 0, 0,  3, 1, 0, 0, 0, 1, 4'hB};
        vecs[6]  = '{1, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0,  3, 2, 0, 0, 0, 1, 4'h1};
        vecs[7]  = '{0, 0, 0, 1, 0, 0, 1, 0,  0, 0, 0,  3, 1, 0, 0, 0, 1, 4'h2};
        vecs[8]  = '{0, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0,  6, 1, 1, 2, 0, 0, 4'h0};
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 1, 0,  2, 1, 0,  6, 1, 3, 0, 0, 1, 4'h5};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 1,  8, 1, 5, 0, 0, 1, 4'h5};
        vecs[11] = '{0, 0, 0, 0, 1, 1, 1, 0,  1, 0, 0,  6, 1, 2, 1, 1, 0, 4'h0};

        drive_idle();
        resetn = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", int'(state_o), 0);
        check("reset outputs", int'({imem_req, dmem_req, ir_load, rf_wen, pc_update, trap_take}), 0);
        check("reset instret", int'(instret), 0);
        check("reset trap_cause", int'(trap_cause), 0);
        resetn = 1;
        #1;
        check("idle after release", int'(state_o), 0);
        @(negedge clk);
        check("first fetch", int'(state_o), 1);

        for (int i = 0; i < 12; i++) do_instr(vecs[i], $sformatf("v%0d", i));

        // retire 16 ALU ops so the 4-bit counter wraps through 15 -> 0
        for (int i = 0; i < 16; i++) do_instr(vecs[0], $sformatf("wrap%0d", i));

        // reset asserted while a data access is outstanding
        begin
            vec_t v;
            int   n = 0;
            v = vecs[10];
            dec_is_mem = 1; dec_wb = 1;
            while (state_o != 4'd4 && n < 20) begin
                imem_ack = (state_o == 4'd1);
                @(negedge clk);
                n++;
            end
            check("reached MEM", int'(state_o), 4);
            #2;
            check("dmem_req before reset", int'(dmem_req), 1);
            resetn = 0;
            #1;
            check("mid-MEM reset state", int'(state_o), 0);
            check("mid-MEM reset outputs", int'({imem_req, dmem_req, ir_load, rf_wen, pc_update, trap_take}), 0);
            check("mid-MEM reset instret", int'(instret), 0);
            check("mid-MEM reset cause", int'(trap_cause), 0);
            drive_idle();
            @(negedge clk);
            resetn = 1;
            @(negedge clk);
            check("fetch after re-reset", int'(state_o), 1);
            if (v.e_cycles != 8) check("vector table intact", v.e_cycles, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
